// File: rtl/fighter_action_sequencer.sv
// Per-player fighter action state machine: input sync, edge latching, frame timing, cooldown.
// Optional input debounce is enabled by defining DEBOUNCE_EN.
module fighter_action_sequencer #(
  parameter int unsigned ATTACK_FRAMES    = 12,
  parameter int unsigned ATK_ACTIVE_START = 4,
  parameter int unsigned ATK_ACTIVE_END   = 7,
  parameter int unsigned PARRY_FRAMES     = 10,
  parameter int unsigned JUMP_FRAMES      = 20,
  parameter int unsigned HITSTUN_FRAMES   = 15,
  parameter int unsigned COOLDOWN_FRAMES  = 8
`ifdef DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES  = 500000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       attack,
  input  logic       pery,
  input  logic       hit,
  output logic [2:0] action_state,
  output logic       action_start,
  output logic       attack_active,
  output logic       parry_active,
  output logic       parry_success,
  output logic       cooldown_busy
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWalkL   = 3'd1,
    StWalkR   = 3'd2,
    StCrouch  = 3'd3,
    StJump    = 3'd4,
    StAttack  = 3'd5,
    StParry   = 3'd6,
    StHitstun = 3'd7
  } state_t;

  localparam logic [5:0] AtkLast  = 6'(ATTACK_FRAMES - 1);
  localparam logic [5:0] ParLast  = 6'(PARRY_FRAMES - 1);
  localparam logic [5:0] JmpLast  = 6'(JUMP_FRAMES - 1);
  localparam logic [5:0] HitLast  = 6'(HITSTUN_FRAMES - 1);
  localparam logic [5:0] AtkStart = 6'(ATK_ACTIVE_START);
  localparam logic [5:0] AtkEnd   = 6'(ATK_ACTIVE_END);
  localparam logic [5:0] CdLoad   = 6'(COOLDOWN_FRAMES);

  // Button vector order: {pery, attack, down, up, right, left}
  logic [5:0] sync1_q, sync2_q, btn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 6'd0;
      sync2_q <= 6'd0;
    end else begin
      sync1_q <= {pery, attack, down, up, right, left};
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [5:0] deb_q;

  for (genvar i = 0; i < 6; i++) begin : g_deb
    logic [DbW-1:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q    <= '0;
        deb_q[i] <= 1'b0;
      end else if (sync2_q[i] == deb_q[i]) begin
        cnt_q <= '0;
      end else if (cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q    <= '0;
        deb_q[i] <= sync2_q[i];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
  assign btn = deb_q;
`else
  assign btn = sync2_q;
`endif

  logic [1:0] prev_q;
  logic       atk_pend_q, par_pend_q, hit_pend_q;
  logic       atk_req, par_req, hit_req;

  // Requests include an edge or hit arriving on the same clk as the tick
  assign atk_req = atk_pend_q | (btn[4] & ~prev_q[0]);
  assign par_req = par_pend_q | (btn[5] & ~prev_q[1]);
  assign hit_req = hit_pend_q | hit;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d, cool_q, cool_d, last_cnt;
  logic       start_q, psucc_q, psucc_d, at_last;

  always_comb begin
    case (state_q)
      StJump:   last_cnt = JmpLast;
      StAttack: last_cnt = AtkLast;
      StParry:  last_cnt = ParLast;
      default:  last_cnt = HitLast;
    endcase
  end
  assign at_last = (cnt_q == last_cnt);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cool_d  = cool_q;
    psucc_d = 1'b0;
    if (frame_tick) begin
      cool_d = (cool_q == 6'd0) ? 6'd0 : cool_q - 6'd1;
      unique case (state_q)
        StIdle, StWalkL, StWalkR, StCrouch: begin
          cnt_d = 6'd0;
          if (hit_req)                          state_d = StHitstun;
          else if (atk_req && cool_q == 6'd0)   state_d = StAttack;
          else if (par_req && cool_q == 6'd0)   state_d = StParry;
          else if (btn[2])                      state_d = StJump;
          else if (btn[3])                      state_d = StCrouch;
          else if (btn[0] && !btn[1])           state_d = StWalkL;
          else if (btn[1] && !btn[0])           state_d = StWalkR;
          else                                  state_d = StIdle;
        end
        StParry: begin
          psucc_d = hit_req;
          if (at_last) begin
            state_d = StIdle;
            cnt_d   = 6'd0;
            cool_d  = CdLoad;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        default: begin
          if (hit_req || at_last) begin
            state_d = hit_req ? StHitstun : StIdle;
            cnt_d   = 6'd0;
            if (state_q == StAttack) cool_d = CdLoad;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      cool_q     <= 6'd0;
      start_q    <= 1'b0;
      psucc_q    <= 1'b0;
      prev_q     <= 2'd0;
      atk_pend_q <= 1'b0;
      par_pend_q <= 1'b0;
      hit_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cool_q     <= cool_d;
      start_q    <= (state_d != state_q);
      psucc_q    <= psucc_d;
      prev_q     <= {btn[5], btn[4]};
      atk_pend_q <= frame_tick ? 1'b0 : atk_req;
      par_pend_q <= frame_tick ? 1'b0 : par_req;
      hit_pend_q <= frame_tick ? 1'b0 : hit_req;
    end
  end

  assign action_state  = state_q;
  assign action_start  = start_q;
  assign attack_active = (state_q == StAttack) && (cnt_q >= AtkStart) && (cnt_q <= AtkEnd);
  assign parry_active  = (state_q == StParry);
  assign parry_success = psucc_q;
  assign cooldown_busy = (cool_q != 6'd0);

endmodule

// File: tb/tb_fighter_action_sequencer.sv
// Bench for fighter_action_sequencer: directed table, corner sequences, random vs reference model.
module tb_fighter_action_sequencer;

  localparam int AtkN = 12, AtkS = 4, AtkE = 7, ParN = 10, JmpN = 20, HitN = 15, CdN = 8;

  logic       clk = 1'b0;
  logic       reset, frame_tick, hit;
  logic       left, right, up, down, attack, pery;
  logic [5:0] btn;
  logic [2:0] action_state;
  logic       action_start, attack_active, parry_active, parry_success, cooldown_busy;

  assign {pery, attack, down, up, right, left} = btn;

  always #5 clk = ~clk;

  fighter_action_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .left          (left),
    .right         (right),
    .up            (up),
    .down          (down),
    .attack        (attack),
    .pery          (pery),
    .hit           (hit),
    .action_state  (action_state),
    .action_start  (action_start),
    .attack_active (attack_active),
    .parry_active  (parry_active),
    .parry_success (parry_success),
    .cooldown_busy (cooldown_busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: buttons seen by the logic are the inputs delayed by the 2-FF synchronizer
  int         m_state, m_cnt, m_cool;
  bit         m_ap, m_pp, m_hp, m_start, m_ps;
  logic [5:0] hist [3];

  function automatic int dur(int s);
    case (s)
      4:       return JmpN;
      5:       return AtkN;
      6:       return ParN;
      default: return HitN;
    endcase
  endfunction

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_cool = 0;
    m_ap = 0; m_pp = 0; m_hp = 0; m_start = 0; m_ps = 0;
    for (int i = 0; i < 3; i++) hist[i] = 6'd0;
  endfunction

  function automatic void model_step(logic [5:0] cur, logic tk, logic ht);
    logic [5:0] lvl, prv;
    bit ar, pr, hr;
    int old, oc;
    lvl = hist[1];
    prv = hist[2];
    ar = m_ap || (lvl[4] && !prv[4]);
    pr = m_pp || (lvl[5] && !prv[5]);
    hr = m_hp || ht;
    m_start = 0;
    m_ps = 0;
    if (tk) begin
      old = m_state;
      oc = m_cool;
      m_cool = (oc > 0) ? oc - 1 : 0;
      if (old < 4) begin
        m_cnt = 0;
        if (hr) m_state = 7;
        else if (ar && oc == 0) m_state = 5;
        else if (pr && oc == 0) m_state = 6;
        else if (lvl[2]) m_state = 4;
        else if (lvl[3]) m_state = 3;
        else if (lvl[0] && !lvl[1]) m_state = 1;
        else if (lvl[1] && !lvl[0]) m_state = 2;
        else m_state = 0;
      end else if (old == 6) begin
        m_ps = hr;
        if (m_cnt == ParN - 1) begin m_state = 0; m_cnt = 0; m_cool = CdN; end
        else m_cnt++;
      end else if (hr || m_cnt == dur(old) - 1) begin
        m_state = hr ? 7 : 0;
        m_cnt = 0;
        if (old == 5) m_cool = CdN;
      end else begin
        m_cnt++;
      end
      m_start = (m_state != old);
      m_ap = 0; m_pp = 0; m_hp = 0;
    end else begin
      m_ap = ar; m_pp = pr; m_hp = hr;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = cur;
  endfunction

  function automatic logic [7:0] dut_pack();
    return {action_state, action_start, attack_active, parry_active, parry_success, cooldown_busy};
  endfunction

  function automatic logic [7:0] mdl_pack();
    logic aa;
    aa = (m_state == 5) && (m_cnt >= AtkS) && (m_cnt <= AtkE);
    return {3'(m_state), m_start, aa, (m_state == 6), m_ps, (m_cool != 0)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic tk, input logic ht);
    frame_tick = tk;
    hit = ht;
    model_step(btn, tk, ht);
    @(posedge clk);
    @(negedge clk);
    chk("model{st,start,aa,pa,ps,cb}", 16'(dut_pack()), 16'(mdl_pack()));
    frame_tick = 1'b0;
    hit = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
    end
  endtask

  typedef struct {
    logic [5:0] b;
    logic       h;
    int         ticks;
    logic [2:0] st;
    logic       aa;
    logic       cb;
  } row_t;

  row_t tbl[$];

  function automatic void add(logic [5:0] b, logic h, int n, logic [2:0] s, logic a, logic c);
    row_t r;
    r.b = b; r.h = h; r.ticks = n; r.st = s; r.aa = a; r.cb = c;
    tbl.push_back(r);
  endfunction

  task automatic run_row(input row_t r, input int idx);
    btn = r.b;
    repeat (3) cycle(1'b0, 1'b0);
    if (r.h) cycle(1'b0, 1'b1);
    tick_n(r.ticks);
    chk($sformatf("row%0d_state", idx), 16'(action_state), 16'(r.st));
    chk($sformatf("row%0d_attack_active", idx), 16'(attack_active), 16'(r.aa));
    chk($sformatf("row%0d_cooldown_busy", idx), 16'(cooldown_busy), 16'(r.cb));
  endtask

  int   gap;
  logic tk, ht;

  initial begin
    btn = 6'd0; frame_tick = 1'b0; hit = 1'b0; reset = 1'b1;
    model_reset();
    @(negedge clk);
    btn = 6'h3f;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 16'(dut_pack()), 16'd0);
    end
    btn = 6'd0;
    @(negedge clk);
    reset = 1'b0;

    // {pery,attack,down,up,right,left}, hit, ticks, state, attack_active, cooldown_busy
    add(6'b001101, 0, 1,  3'd4, 0, 0);  // up beats down and left
    add(6'b000000, 0, 19, 3'd4, 0, 0);
    add(6'b000000, 0, 1,  3'd0, 0, 0);
    add(6'b000011, 0, 1,  3'd0, 0, 0);  // left+right cancel
    add(6'b000001, 0, 1,  3'd1, 0, 0);
    add(6'b000010, 0, 1,  3'd2, 0, 0);
    add(6'b001000, 0, 1,  3'd3, 0, 0);
    add(6'b010000, 0, 1,  3'd5, 0, 0);
    add(6'b010000, 0, 4,  3'd5, 1, 0);
    add(6'b010000, 0, 3,  3'd5, 1, 0);
    add(6'b010000, 0, 1,  3'd5, 0, 0);
    add(6'b010000, 0, 3,  3'd5, 0, 0);
    add(6'b010000, 0, 1,  3'd0, 0, 1);
    add(6'b000000, 0, 1,  3'd0, 0, 1);
    add(6'b010000, 0, 1,  3'd0, 0, 1);  // attack blocked by cooldown
    add(6'b000001, 0, 1,  3'd1, 0, 1);
    add(6'b010001, 0, 1,  3'd1, 0, 1);
    add(6'b000001, 0, 4,  3'd1, 0, 0);
    add(6'b010001, 0, 1,  3'd5, 0, 0);  // cooldown expired
    add(6'b000000, 0, 11, 3'd5, 0, 0);
    add(6'b000000, 0, 1,  3'd0, 0, 1);
    add(6'b000000, 0, 8,  3'd0, 0, 0);
    add(6'b100000, 0, 1,  3'd6, 0, 0);
    add(6'b000000, 0, 3,  3'd6, 0, 0);
    add(6'b000000, 1, 1,  3'd6, 0, 0);  // parried hit
    add(6'b000000, 0, 5,  3'd6, 0, 0);
    add(6'b000000, 0, 1,  3'd0, 0, 1);
    add(6'b000000, 0, 8,  3'd0, 0, 0);
    add(6'b010000, 0, 1,  3'd5, 0, 0);
    add(6'b000000, 0, 2,  3'd5, 0, 0);
    add(6'b000000, 1, 1,  3'd7, 0, 1);  // hit interrupts attack
    add(6'b000000, 0, 10, 3'd7, 0, 0);
    add(6'b000000, 1, 1,  3'd7, 0, 0);  // hitstun restart
    add(6'b000000, 0, 14, 3'd7, 0, 0);
    add(6'b000000, 0, 1,  3'd0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

    btn = 6'b000100;
    repeat (3) cycle(1'b0, 1'b0);
    chk("start_before_tick", 16'(action_start), 16'd0);
    cycle(1'b1, 1'b0);
    chk("start_state", 16'(action_state), 16'd4);
    chk("start_pulse", 16'(action_start), 16'd1);
    cycle(1'b0, 1'b0);
    chk("start_clear", 16'(action_start), 16'd0);
    btn = 6'd0;
    tick_n(JmpN);

    btn = 6'b010000;
    repeat (3) cycle(1'b0, 1'b0);
    tick_n(1);
    btn = 6'b000100;
    tick_n(AtkN + 1);
    chk("midreset_pre_state", 16'(action_state), 16'd4);
    chk("midreset_pre_cb", 16'(cooldown_busy), 16'd1);
    #2 reset = 1'b1;
    #1 chk("midreset_outputs", 16'(dut_pack()), 16'd0);
    model_reset();
    @(negedge clk);
    chk("midreset_hold", 16'(dut_pack()), 16'd0);
    btn = 6'd0;
    reset = 1'b0;
    repeat (4) cycle(1'b0, 1'b0);

    gap = 0;
    for (int i = 0; i < 4000; i++) begin
      if (gap == 0) begin
        tk = 1'b1;
        gap = $urandom_range(1, 4);
      end else begin
        tk = 1'b0;
        gap--;
      end
      ht = !tk && ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) btn = btn ^ (6'd1 << $urandom_range(0, 5));
      cycle(tk, ht);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
